// File: rtl/crc16_checker_if.sv
// Handshake and result bundle between a codeword source and crc16_checker.
interface crc16_checker_if #(
  parameter int unsigned DATA_W = 34,
  parameter int unsigned CRC_W  = 16
);
  logic                      start;
  logic [DATA_W+CRC_W-1:0]   code_in;
  logic                      busy;
  logic                      done;
  logic                      crc_ok;
  logic [CRC_W-1:0]          syndrome;
  logic [DATA_W-1:0]         data_out;

  modport master (
    output start, code_in,
    input  busy, done, crc_ok, syndrome, data_out
  );

  modport slave (
    input  start, code_in,
    output busy, done, crc_ok, syndrome, data_out
  );
endinterface

// File: rtl/crc16_checker.sv
// Bit-serial CRC-16 codeword checker: divides a captured codeword MSB-first by
// the generator polynomial and reports the remainder, a pass flag and the payload.
module crc16_checker #(
  parameter int unsigned    DATA_W = 34,
  parameter int unsigned    CRC_W  = 16,
  parameter logic [CRC_W-1:0] POLY = 16'h8005
) (
  input logic              clk,
  input logic              reset,
  crc16_checker_if.slave   bus
);
  localparam int unsigned CODE_W = DATA_W + CRC_W;
  localparam int unsigned CNT_W  = $clog2(CODE_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CODE_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   sreg_q, sreg_d;
  logic [CRC_W-1:0]    lfsr_q, lfsr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   payload_q, payload_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                crc_ok_q, crc_ok_d;
  logic [CRC_W-1:0]    syndrome_q, syndrome_d;
  logic [DATA_W-1:0]   data_q, data_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // done/busy are registered, so the done cycle is already IDLE and a held
  // start is accepted there, giving back-to-back checks every 52 cycles.
  always_comb begin
    sreg_d     = sreg_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    payload_d  = payload_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    crc_ok_d   = crc_ok_q;
    syndrome_d = syndrome_q;
    data_d     = data_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sreg_d    = bus.code_in;
          lfsr_d    = '0;
          cnt_d     = '0;
          payload_d = bus.code_in[CODE_W-1 -: DATA_W];
          busy_d    = 1'b1;
        end
      end
      SHIFT: begin
        sreg_d = {sreg_q[CODE_W-2:0], 1'b0};
        lfsr_d = {lfsr_q[CRC_W-2:0], sreg_q[CODE_W-1]} ^ (lfsr_q[CRC_W-1] ? POLY : '0);
        cnt_d  = cnt_q + 1'b1;
        busy_d = 1'b1;
      end
      DONE: begin
        busy_d     = 1'b1;
        done_d     = 1'b1;
        syndrome_d = lfsr_q;
        crc_ok_d   = (lfsr_q == '0);
        data_d     = payload_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg_q     <= '0;
      lfsr_q     <= '0;
      cnt_q      <= '0;
      payload_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      crc_ok_q   <= 1'b0;
      syndrome_q <= '0;
      data_q     <= '0;
    end else begin
      sreg_q     <= sreg_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      payload_q  <= payload_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      crc_ok_q   <= crc_ok_d;
      syndrome_q <= syndrome_d;
      data_q     <= data_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.crc_ok   = crc_ok_q;
  assign bus.syndrome = syndrome_q;
  assign bus.data_out = data_q;
endmodule

// File: tb/tb_crc16_checker.sv
// Scoreboard bench for crc16_checker: stimulus queues expected results, a
// monitor compares them at each done pulse.
module tb_crc16_checker;
  logic clk;
  logic reset;

  crc16_checker_if #(.DATA_W(34), .CRC_W(16)) bus ();

  crc16_checker #(.DATA_W(34), .CRC_W(16), .POLY(16'h8005)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ok;
    logic [15:0] syn;
    logic [33:0] data;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference division: plain long division by x^16+x^15+x^2+1 over the 50 bits.
  function automatic logic [15:0] rem50(input logic [49:0] v);
    logic [49:0] r;
    logic [49:0] p;
    r = v;
    p = 50'h18005;
    for (int i = 49; i >= 16; i--)
      if (r[i]) r = r ^ (p << (i - 16));
    return r[15:0];
  endfunction

  always @(negedge clk) begin
    if (reset && bus.done) begin
      chk("sb_expected_pending", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("crc_ok",   64'(bus.crc_ok),   64'(e.ok));
        chk("syndrome", 64'(bus.syndrome), 64'(e.syn));
        chk("data_out", 64'(bus.data_out), 64'(e.data));
      end
    end
  end

  task automatic push_exp(input logic ok, input logic [15:0] syn, input logic [33:0] data);
    exp_t e;
    e.ok = ok; e.syn = syn; e.data = data;
    q.push_back(e);
  endtask

  task automatic run_check(input logic [49:0] code, input logic ok,
                           input logic [15:0] syn, input logic [33:0] data);
    int lat;
    bit seen;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.code_in = code;
    push_exp(ok, syn, data);
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.code_in = ~code;
    @(negedge clk);
    chk("busy_after_accept", 64'(bus.busy), 64'd1);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    chk("latency", 64'(lat), 64'd51);
    chk("busy_in_done_cycle", 64'(bus.busy), 64'd1);
    @(negedge clk);
    chk("done_one_cycle", 64'(bus.done), 64'd0);
    chk("busy_cleared", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] lb_data;
    logic [15:0] lb_crc;
    logic [49:0] lb_code;
    logic [49:0] flip;
    logic [49:0] one;
    int ndone, done_at, doubles, prev_done;
    int at[$];

    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.code_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",     64'(bus.busy),     64'd0);
    chk("rst_done",     64'(bus.done),     64'd0);
    chk("rst_crc_ok",   64'(bus.crc_ok),   64'd0);
    chk("rst_syndrome", 64'(bus.syndrome), 64'd0);
    chk("rst_data_out", 64'(bus.data_out), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Directed vectors with hand-derived remainders.
    run_check(50'h0,     1'b1, 16'h0000, 34'h0);
    run_check(50'h18005, 1'b1, 16'h0000, 34'h1);
    run_check(50'h10000, 1'b0, 16'h8005, 34'h1);
    run_check(50'h1,     1'b0, 16'h0001, 34'h0);

    // Loopback through a generator, then every single-bit error.
    lb_data = 34'h155555555;
    lb_crc  = rem50({lb_data, 16'h0000});
    lb_code = {lb_data, lb_crc};
    run_check(lb_code, 1'b1, 16'h0000, 34'h155555555);
    one = 50'h1;
    for (int k = 0; k < 50; k++) begin
      flip = lb_code ^ (one << k);
      run_check(flip, 1'b0, rem50(flip), flip[49:16]);
    end

    // Start held high for 200 cycles.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.code_in = 50'h18005;
    for (int i = 0; i < 4; i++) push_exp(1'b1, 16'h0000, 34'h1);
    doubles   = 0;
    prev_done = 0;
    for (int c = 0; c < 260; c++) begin
      @(negedge clk);
      if (bus.done && prev_done != 0) doubles++;
      if (bus.done && prev_done == 0) at.push_back(c);
      prev_done = int'(bus.done);
      if (c == 199) bus.start = 1'b0;
    end
    chk("held_done_count", 64'(at.size()), 64'd4);
    chk("held_done_width", 64'(doubles), 64'd0);
    if (at.size() == 4) begin
      chk("held_first_done", 64'(at[0]), 64'd51);
      for (int i = 1; i < 4; i++)
        chk("held_done_spacing", 64'(at[i] - at[i-1]), 64'd52);
    end

    // Extra start pulses while busy must not spawn another check.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.code_in = 50'h1;
    push_exp(1'b0, 16'h0001, 34'h0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    ndone   = 0;
    done_at = -1;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (bus.done) begin ndone++; done_at = c; end
      bus.start = (c == 10 || c == 30 || c == 50);
    end
    bus.start = 1'b0;
    chk("busy_start_done_count", 64'(ndone), 64'd1);
    chk("busy_start_done_at", 64'(done_at), 64'd51);

    // Reset in the middle of a check.
    run_check(50'h10000, 1'b0, 16'h8005, 34'h1);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.code_in = 50'h18005;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy",     64'(bus.busy),     64'd0);
    chk("abort_done",     64'(bus.done),     64'd0);
    chk("abort_crc_ok",   64'(bus.crc_ok),   64'd0);
    chk("abort_syndrome", 64'(bus.syndrome), 64'd0);
    chk("abort_data_out", 64'(bus.data_out), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    run_check(50'h18005, 1'b1, 16'h0000, 34'h1);

    for (int c = 0; c < 100 && q.size() != 0; c++) @(negedge clk);
    chk("sb_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/crc16_checker.md
# crc16_checker

Receive-side counterpart of the team's serial CRC-16 generator. Accepts a 50-bit codeword (34 data bits followed by a 16-bit CRC), divides it bit-serially MSB-first by the generator polynomial, and reports whether the remainder is zero. It also returns the recovered 34-bit payload and the 16-bit syndrome. It sits at the receive end of the link, after the codeword has been captured in parallel.

## Interface
Parameters:
- DATA_W, 34, payload width
- CRC_W, 16, CRC width; codeword width is DATA_W+CRC_W = 50
- POLY, 16'h8005, generator polynomial without the x^16 term (x^16+x^15+x^2+1)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; reset=0 forces reset state immediately
- start  in  1  request check of code_in; sampled only in IDLE
- code_in  in  50  codeword: [49:16] data MSB-first, [15:0] CRC
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; result outputs valid from this cycle
- crc_ok  out  1  1 = syndrome is zero
- syndrome  out  16  remainder of codeword mod (x^16+POLY)
- data_out  out  34  code_in[49:16] of the checked word

## Operation
- States: IDLE, SHIFT, DONE. Reset value: IDLE, busy=0, done=0, crc_ok=0, syndrome=0, data_out=0, internal LFSR, shift register and counter all 0.
- IDLE: when start=1, load code_in into the 50-bit shift register, clear the LFSR, set the counter to 0, and go to SHIFT. With start=0, stay in IDLE.
- SHIFT: on each edge, b = sreg[49]; sreg <= sreg<<1; lfsr <= {lfsr[14:0],b} ^ (lfsr[15] ? POLY : 0); counter+1. After the 50th bit (counter reaches 49), go to DONE.
- The LFSR computes C(x) mod P(x) directly, with no initial value and no final XOR. A correct codeword has data·x^16 + (data·x^16 mod P), so its remainder is 0.
- DONE: register syndrome <= lfsr, crc_ok <= (lfsr==0), data_out <= captured payload; done=1 for exactly this cycle; go to IDLE.
- The captured payload is held in a separate 34-bit register loaded with start, so code_in may change freely after acceptance.
- start while in SHIFT or DONE is ignored; no queueing.
- Result outputs hold their last value until the next DONE, and are not cleared on start.
- reset asserted mid-operation aborts the check. The next start after release begins a fresh check.

## Timing
- Edge 0: start=1 sampled in IDLE, codeword captured.
- Edges 1..50: 50 shift steps; busy=1 during these cycles.
- Edge 51: results registered; done=1 and busy=1 in the following cycle.
- Edge 52: back in IDLE; busy=0, done=0.
- Latency from start sample to done asserted: 51 cycles.
- start held continuously high: a new check accepted every 52 cycles.
- reset is asynchronous on assertion. Deassertion is synchronous to clk externally; the block needs no internal synchronizer.

## Test plan
- code_in=50'h0, start pulse → done after 51 cycles, crc_ok=1, syndrome=16'h0000, data_out=34'h0.
- code_in=50'h18005 (data 34'h1, CRC 16'h8005) → crc_ok=1, syndrome=16'h0000, data_out=34'h1.
- code_in=50'h10000 (data 34'h1, CRC 16'h0000) → crc_ok=0, syndrome=16'h8005, data_out=34'h1. Also code_in=50'h1 → crc_ok=0, syndrome=16'h0001, data_out=0.
- Loopback: data 34'b0101…01 through the CRC-16 generator, its 50-bit output applied here → crc_ok=1, data_out=34'h155555555. Then flip each of the 50 bits in turn → crc_ok=0 every time.
- Handshake: start held high for 200 cycles → done pulses exactly 52 cycles apart, each one cycle wide. Extra start pulses during busy produce no extra done.
- reset=0 at cycle 20 of a check → busy, done, crc_ok and syndrome go to 0 immediately with no done pulse. After release, start with 50'h18005 → normal result after 51 cycles.
